tlc5940_rx_model: RTL and testbench

- Synthesizable receiver-side model of the TI TLC5940 16-channel PWM LED driver.
- Consumes the serial/control pins produced by the TLC5940 driver wrappers (sin, sclk, xlat, blank, vprg, dcprg, gsclk), oversampled on the fabric clock.
- Reconstructs the latched grayscale and dot-correction data and the 16 PWM channel states.
- Used as the far-end device in driver benches and as an on-FPGA loopback checker.

---
 rtl/tlc5940_pkg.sv | 34 +++
 rtl/tlc5940_rx_model_if.sv | 25 ++
 rtl/tlc5940_pin_sync.sv | 38 +++
 rtl/tlc5940_rx_model.sv | 174 +++++++++++++++++
 tb/tb_tlc5940_rx_model.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlc5940_pkg.sv
// rtl/tlc5940_pkg.sv - shared constants, channel types and pin indices for the TLC5940 receiver model
package tlc5940_pkg;

    localparam int GS_BITS = 12;
    localparam int DC_BITS = 6;
    localparam int NUM_CH  = 16;
    localparam int GS_LEN  = NUM_CH * GS_BITS;
    localparam int DC_LEN  = NUM_CH * DC_BITS;

    typedef logic [GS_BITS-1:0] gs_ch_t;
    typedef logic [DC_BITS-1:0] dc_ch_t;
    // One extra bit so the counter can sit at 4096 (end of PWM cycle).
    typedef logic [GS_BITS:0]   gs_cnt_t;

    localparam gs_cnt_t GS_MAX            = gs_cnt_t'(4096);
    localparam gs_ch_t  GS_COUNT_HOLD     = 12'hFFF;
    localparam dc_ch_t  DC_EEPROM_DEFAULT = 6'h3F;
    localparam logic [7:0] SCLK_COUNT_MAX = 8'hFF;

    // Index of each device pin in the synchronizer bank.
    localparam int NUM_PINS  = 7;
    localparam int PIN_SIN   = 0;
    localparam int PIN_SCLK  = 1;
    localparam int PIN_XLAT  = 2;
    localparam int PIN_BLANK = 3;
    localparam int PIN_VPRG  = 4;
    localparam int PIN_DCPRG = 5;
    localparam int PIN_GSCLK = 6;

    function automatic gs_ch_t gs_chan(input logic [GS_LEN-1:0] gs, input int ch);
        return gs[ch*GS_BITS +: GS_BITS];
    endfunction

endpackage

// File: rtl/tlc5940_rx_model_if.sv
// rtl/tlc5940_rx_model_if.sv - TLC5940 serial/control pin bundle between driver and device
interface tlc5940_rx_model_if;

    logic sin;
    logic sclk;
    logic xlat;
    logic blank;
    logic vprg;
    logic dcprg;
    logic gsclk;
    logic sout;

    // Driver side (the wrapper under test or the bench).
    modport master (
        output sin, sclk, xlat, blank, vprg, dcprg, gsclk,
        input  sout
    );

    // Device side (this receiver model).
    modport slave (
        input  sin, sclk, xlat, blank, vprg, dcprg, gsclk,
        output sout
    );

endinterface

// File: rtl/tlc5940_pin_sync.sv
// rtl/tlc5940_pin_sync.sv - multi-flop pin synchronizer with registered rising-edge detect
module tlc5940_pin_sync #(
    parameter int SYNC_STAGES = 2           // at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,                       // asynchronous device pin
    output logic level,                     // synchronized level, aligned with rise
    output logic rise                       // 1-clk pulse on a rising edge of pin
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
        // level is delayed one extra flop so data pins line up with edge pulses.
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/tlc5940_rx_model.sv
// rtl/tlc5940_rx_model.sv - receiver-side TLC5940 model: shift/latch, DC select, GS counter and PWM outputs
module tlc5940_rx_model #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = tlc5940_pkg::NUM_CH
) (
    input  logic                              clk,
    input  logic                              rst,
    tlc5940_rx_model_if.slave                 pins,            // serial/control pins, sout back
    output logic [NUM_CH-1:0]                 out_on,          // channel driven
    output logic [tlc5940_pkg::GS_LEN-1:0]    gs_latched,      // ch15 at top
    output logic [tlc5940_pkg::DC_LEN-1:0]    dc_effective,    // ch15 at top
    output logic [tlc5940_pkg::GS_BITS-1:0]   gs_count,
    output logic [7:0]                        sclk_count,
    output logic                              gs_latch_pulse,
    output logic                              dc_latch_pulse,
    output logic                              cycle_done
);

    import tlc5940_pkg::*;

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic [NUM_PINS-1:0] pin_raw, pin_lvl, pin_rise;

    assign pin_raw[PIN_SIN]   = pins.sin;
    assign pin_raw[PIN_SCLK]  = pins.sclk;
    assign pin_raw[PIN_XLAT]  = pins.xlat;
    assign pin_raw[PIN_BLANK] = pins.blank;
    assign pin_raw[PIN_VPRG]  = pins.vprg;
    assign pin_raw[PIN_DCPRG] = pins.dcprg;
    assign pin_raw[PIN_GSCLK] = pins.gsclk;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
        tlc5940_pin_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .pin   (pin_raw[i]),
            .level (pin_lvl[i]),
            .rise  (pin_rise[i])
        );
    end

    logic sin_s, vprg_s, dcprg_s, blank_s;
    logic sclk_rise, xlat_rise, gsclk_rise;

    assign sin_s      = pin_lvl[PIN_SIN];
    assign vprg_s     = pin_lvl[PIN_VPRG];
    assign dcprg_s    = pin_lvl[PIN_DCPRG];
    assign blank_s    = pin_lvl[PIN_BLANK];
    assign sclk_rise  = pin_rise[PIN_SCLK];
    assign xlat_rise  = pin_rise[PIN_XLAT];
    assign gsclk_rise = pin_rise[PIN_GSCLK];

    // Data pins only need levels and clock pins only need edges.
    logic unused_ok;
    assign unused_ok = &{1'b0, pin_rise[PIN_SIN], pin_rise[PIN_VPRG], pin_rise[PIN_DCPRG],
                         pin_rise[PIN_BLANK], pin_lvl[PIN_SCLK], pin_lvl[PIN_XLAT],
                         pin_lvl[PIN_GSCLK]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [GS_LEN-1:0] shift_q, shift_d;
    logic [GS_LEN-1:0] gs_latched_q, gs_latched_d;
    logic [DC_LEN-1:0] dc_reg_q, dc_reg_d;
    logic [7:0]        sclk_count_q, sclk_count_d;
    logic              discard_q, discard_d;
    gs_cnt_t           cnt_q, cnt_d;
    logic [NUM_CH-1:0] out_on_q, out_on_d;
    logic              gs_latch_pulse_q, gs_latch_pulse_d;
    logic              dc_latch_pulse_q, dc_latch_pulse_d;
    logic              cycle_done_q, cycle_done_d;

    // Shift register and latches. The shift result is computed first so a
    // latch in the same clk captures the post-shift value.
    always_comb begin
        shift_d          = shift_q;
        gs_latched_d     = gs_latched_q;
        dc_reg_d         = dc_reg_q;
        sclk_count_d     = sclk_count_q;
        discard_d        = discard_q;
        gs_latch_pulse_d = 1'b0;
        dc_latch_pulse_d = 1'b0;

        if (sclk_rise) begin
            if (discard_q) begin
                // Extra SCLK the device swallows after a DC latch.
                discard_d = 1'b0;
            end else begin
                shift_d = {shift_q[GS_LEN-2:0], sin_s};
                if (sclk_count_q != SCLK_COUNT_MAX) begin
                    sclk_count_d = sclk_count_q + 8'd1;
                end
            end
        end

        if (xlat_rise) begin
            sclk_count_d = '0;
            if (vprg_s) begin
                dc_reg_d         = shift_d[DC_LEN-1:0];
                discard_d        = 1'b1;
                dc_latch_pulse_d = 1'b1;
            end else begin
                gs_latched_d     = shift_d;
                gs_latch_pulse_d = 1'b1;
            end
        end
    end

    // Grayscale counter and PWM compare. out_on uses the registered counter
    // and registered gs_latched, so it trails a counter update by one clk.
    always_comb begin
        cnt_d        = cnt_q;
        cycle_done_d = 1'b0;
        out_on_d     = '0;

        if (blank_s) begin
            cnt_d = '0;
        end else if (gsclk_rise && (cnt_q != GS_MAX)) begin
            cnt_d = cnt_q + gs_cnt_t'(1);
            if (cnt_d == GS_MAX) begin
                cycle_done_d = 1'b1;
            end
        end

        for (int n = 0; n < NUM_CH; n++) begin
            out_on_d[n] = !blank_s && (cnt_q < {1'b0, gs_chan(gs_latched_q, n)});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q          <= '0;
            gs_latched_q     <= '0;
            dc_reg_q         <= '0;
            sclk_count_q     <= '0;
            discard_q        <= 1'b0;
            cnt_q            <= '0;
            out_on_q         <= '0;
            gs_latch_pulse_q <= 1'b0;
            dc_latch_pulse_q <= 1'b0;
            cycle_done_q     <= 1'b0;
        end else begin
            shift_q          <= shift_d;
            gs_latched_q     <= gs_latched_d;
            dc_reg_q         <= dc_reg_d;
            sclk_count_q     <= sclk_count_d;
            discard_q        <= discard_d;
            cnt_q            <= cnt_d;
            out_on_q         <= out_on_d;
            gs_latch_pulse_q <= gs_latch_pulse_d;
            dc_latch_pulse_q <= dc_latch_pulse_d;
            cycle_done_q     <= cycle_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pins.sout      = shift_q[GS_LEN-1];
    assign out_on         = out_on_q;
    assign gs_latched     = gs_latched_q;
    assign dc_effective   = dcprg_s ? dc_reg_q : {NUM_CH{DC_EEPROM_DEFAULT}};
    // The 4096 end-of-cycle state reads as 4095 on the 12-bit output.
    assign gs_count       = (cnt_q == GS_MAX) ? GS_COUNT_HOLD : cnt_q[GS_BITS-1:0];
    assign sclk_count     = sclk_count_q;
    assign gs_latch_pulse = gs_latch_pulse_q;
    assign dc_latch_pulse = dc_latch_pulse_q;
    assign cycle_done     = cycle_done_q;

endmodule

// File: tb/tb_tlc5940_rx_model.sv
// tb/tb_tlc5940_rx_model.sv - scoreboard bench for the TLC5940 receiver model
module tb_tlc5940_rx_model;

    localparam int K_GS  = 0;
    localparam int K_DC  = 1;
    localparam int K_CYC = 2;

    typedef struct {
        int           kind;
        logic [191:0] gs;
        logic [95:0]  dc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [15:0]  out_on;
    logic [191:0] gs_latched;
    logic [95:0]  dc_effective;
    logic [11:0]  gs_count;
    logic [7:0]   sclk_count;
    logic         gs_latch_pulse;
    logic         dc_latch_pulse;
    logic         cycle_done;

    tlc5940_rx_model_if pins ();

    tlc5940_rx_model #(
        .SYNC_STAGES (2),
        .NUM_CH      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pins           (pins),
        .out_on         (out_on),
        .gs_latched     (gs_latched),
        .dc_effective   (dc_effective),
        .gs_count       (gs_count),
        .sclk_count     (sclk_count),
        .gs_latch_pulse (gs_latch_pulse),
        .dc_latch_pulse (dc_latch_pulse),
        .cycle_done     (cycle_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference model: the stream of accepted serial bits and PWM counter.
    bit           acc[$];
    int           m_sclk;
    bit           m_discard;
    bit           m_vprg;
    bit           m_dcprg;
    bit           m_blank;
    int           m_cnt;
    logic [191:0] m_gs;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Last 192 accepted bits; the most recent bit sits at position 0.
    function automatic logic [191:0] last_bits();
        logic [191:0] r;
        r = '0;
        for (int i = 0; i < 192; i++) begin
            int idx;
            idx = acc.size() - 1 - i;
            if (idx >= 0) r[i] = acc[idx];
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_on();
        logic [15:0] r;
        for (int n = 0; n < 16; n++) begin
            r[n] = !m_blank && (m_cnt < int'(m_gs[n*12 +: 12]));
        end
        return r;
    endfunction

    task automatic model_sclk(input bit b);
        if (m_discard) begin
            m_discard = 1'b0;
        end else begin
            acc.push_back(b);
            if (m_sclk < 255) m_sclk++;
        end
    endtask

    task automatic model_latch();
        exp_t         e;
        logic [191:0] lb;
        lb   = last_bits();
        e.gs = '0;
        e.dc = '0;
        if (m_vprg) begin
            e.kind    = K_DC;
            e.dc      = m_dcprg ? lb[95:0] : {16{6'h3F}};
            m_discard = 1'b1;
        end else begin
            e.kind = K_GS;
            e.gs   = lb;
            m_gs   = lb;
        end
        m_sclk = 0;
        exp_q.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input bit b);
        model_sclk(b);
        pins.sin = b;
        wait_clk(2);
        pins.sclk = 1'b1;
        wait_clk(2);
        pins.sclk = 1'b0;
    endtask

    task automatic shift_vec(input logic [191:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(v[i]);
        wait_clk(4);
    endtask

    task automatic xlat_pulse();
        model_latch();
        pins.xlat = 1'b1;
        wait_clk(2);
        pins.xlat = 1'b0;
        wait_clk(6);
    endtask

    // Final sclk rise and xlat rise land on the same clk.
    task automatic shift_bit_with_xlat(input bit b);
        model_sclk(b);
        model_latch();
        pins.sin = b;
        wait_clk(2);
        pins.sclk = 1'b1;
        pins.xlat = 1'b1;
        wait_clk(2);
        pins.sclk = 1'b0;
        pins.xlat = 1'b0;
        wait_clk(6);
    endtask

    task automatic gsclk_pulse();
        exp_t e;
        if (!m_blank && m_cnt < 4096) begin
            m_cnt++;
            if (m_cnt == 4096) begin
                e.kind = K_CYC;
                e.gs   = '0;
                e.dc   = '0;
                exp_q.push_back(e);
            end
        end
        pins.gsclk = 1'b1;
        wait_clk(2);
        pins.gsclk = 1'b0;
        wait_clk(2);
    endtask

    task automatic set_blank(input bit b);
        m_blank = b;
        if (b) m_cnt = 0;
        pins.blank = b;
        wait_clk(6);
    endtask

    task automatic check_pwm(input string tag);
        wait_clk(2);
        chk({tag, "_gs_count"}, gs_count, (m_cnt == 4096) ? 4095 : m_cnt);
        chk({tag, "_out_on"}, out_on, exp_on());
    endtask

    task automatic model_reset();
        acc.delete();
        m_sclk    = 0;
        m_discard = 1'b0;
        m_cnt     = 0;
        m_gs      = '0;
    endtask

    // Monitor: every latch / cycle-end pulse pops one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (gs_latch_pulse || dc_latch_pulse || cycle_done)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%b%b%b expected=none",
                         gs_latch_pulse, dc_latch_pulse, cycle_done);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {gs_latch_pulse, dc_latch_pulse, cycle_done},
                    {e.kind == K_GS, e.kind == K_DC, e.kind == K_CYC});
                case (e.kind)
                    K_GS:    chk("gs_latched", gs_latched, e.gs);
                    K_DC:    chk("dc_effective", dc_effective, e.dc);
                    default: chk("cycle_gs_count", gs_count, 12'hFFF);
                endcase
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [191:0] v;
        logic [95:0]  d;

        rst        = 1'b1;
        pins.sin   = 1'b0;
        pins.sclk  = 1'b0;
        pins.xlat  = 1'b0;
        pins.blank = 1'b1;
        pins.vprg  = 1'b0;
        pins.dcprg = 1'b0;
        pins.gsclk = 1'b0;
        m_vprg     = 1'b0;
        m_dcprg    = 1'b0;
        m_blank    = 1'b1;
        model_reset();
        wait_clk(4);

        chk("rst_gs_latched", gs_latched, '0);
        chk("rst_sclk_count", sclk_count, 0);
        chk("rst_gs_count", gs_count, 0);
        chk("rst_out_on", out_on, 0);
        chk("rst_sout", pins.sout, 0);
        chk("rst_dc_effective", dc_effective, {16{6'h3F}});
        chk("rst_pulses", {gs_latch_pulse, dc_latch_pulse, cycle_done}, 0);
        rst = 1'b0;
        wait_clk(4);

        // GS load with fixed channel values.
        v          = '0;
        v[191:180] = 12'hABC;
        v[11:0]    = 12'h123;
        shift_vec(v, 192);
        chk("pre_latch_sclk_count", sclk_count, m_sclk);
        chk("sout_msb", pins.sout, last_bits() >> 191);
        xlat_pulse();
        chk("post_latch_sclk_count", sclk_count, m_sclk);
        chk("gs_ch15", gs_latched[191:180], 12'hABC);
        chk("gs_ch0", gs_latched[11:0], 12'h123);

        // DC load, then a GS load whose first sclk is swallowed.
        pins.dcprg = 1'b1;
        m_dcprg    = 1'b1;
        pins.vprg  = 1'b1;
        m_vprg     = 1'b1;
        d          = {$urandom, $urandom, $urandom};
        d[5:0]     = 6'h15;
        wait_clk(4);
        shift_vec({96'b0, d}, 96);
        xlat_pulse();
        chk("dc_ch0", dc_effective[5:0], 6'h15);
        pins.vprg = 1'b0;
        m_vprg    = 1'b0;
        wait_clk(4);
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        shift_bit($urandom_range(0, 1));
        shift_vec(v, 192);
        chk("discard_sclk_count", sclk_count, m_sclk);
        xlat_pulse();
        chk("discard_gs_matches_last192", gs_latched, v);

        // Saturating sclk_count, then a load whose last sclk coincides with xlat.
        for (int n = 0; n < 16; n++) v[n*12 +: 12] = 12'($urandom_range(1, 4095));
        v[47:36] = 12'd10;
        v[11:0]  = 12'd0;
        for (int i = 0; i < 70; i++) shift_bit($urandom_range(0, 1));
        for (int i = 191; i >= 1; i--) shift_bit(v[i]);
        wait_clk(4);
        chk("sclk_count_saturated", sclk_count, m_sclk);
        shift_bit_with_xlat(v[0]);
        chk("coincident_sclk_count", sclk_count, m_sclk);

        // PWM: ch3 = 10, ch0 = 0.
        set_blank(1'b0);
        check_pwm("unblank");
        for (int i = 0; i < 20; i++) begin
            gsclk_pulse();
            check_pwm("gsclk_step");
        end
        set_blank(1'b1);
        set_blank(1'b0);
        for (int i = 0; i < 5; i++) gsclk_pulse();
        check_pwm("pre_coincident");

        // blank rising together with a gsclk edge.
        m_blank    = 1'b1;
        m_cnt      = 0;
        pins.blank = 1'b1;
        pins.gsclk = 1'b1;
        wait_clk(2);
        pins.gsclk = 1'b0;
        wait_clk(4);
        check_pwm("blank_with_gsclk");
        set_blank(1'b0);
        check_pwm("unblank2");

        // Full cycle plus overrun.
        for (int i = 0; i < 4100; i++) gsclk_pulse();
        check_pwm("saturated");
        set_blank(1'b1);
        set_blank(1'b0);
        check_pwm("restart");
        set_blank(1'b1);

        // Reset in the middle of a transfer.
        pins.dcprg = 1'b0;
        m_dcprg    = 1'b0;
        for (int i = 0; i < 100; i++) shift_bit($urandom_range(0, 1));
        wait_clk(4);
        chk("mid_sclk_count", sclk_count, m_sclk);
        rst = 1'b1;
        model_reset();
        wait_clk(3);
        chk("mid_rst_gs_latched", gs_latched, '0);
        chk("mid_rst_sclk_count", sclk_count, 0);
        chk("mid_rst_out_on", out_on, 0);
        chk("mid_rst_gs_count", gs_count, 0);
        chk("mid_rst_sout", pins.sout, 0);
        rst = 1'b0;
        wait_clk(4);
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        shift_vec(v, 192);
        chk("post_rst_sclk_count", sclk_count, m_sclk);
        xlat_pulse();
        chk("post_rst_gs", gs_latched, v);
        chk("eeprom_dc", dc_effective, {16{6'h3F}});

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_clk(1);
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
